// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer with bit pacing and serializer strobes
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_shift,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          par_en_q;
  logic [1:0]    mux_q;
  logic          busy_q;
  logic          ser_en_q;

  logic          cnt_last;
  logic          idx_last;
  logic          accept;

  // Bit-boundary and acceptance decode shared by the FSM and the strobes
  always_comb begin
    cnt_last = (cnt_q == CNT_LAST);
    idx_last = (idx_q == IDX_LAST);
    accept   = RST && Data_Valid &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && cnt_last));
  end

  // Frame FSM with bit pacing counters and registered Moore outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      par_en_q <= 1'b0;
      mux_q    <= MUX_STOP;
      busy_q   <= 1'b0;
      ser_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (Data_Valid) begin
            state_q  <= S_START;
            par_en_q <= PAR_EN;
            mux_q    <= MUX_START;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_last) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= S_DATA;
            mux_q    <= MUX_DATA;
            ser_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (idx_last) begin
              idx_q    <= '0;
              ser_en_q <= 1'b0;
              if (par_en_q) begin
                state_q <= S_PARITY;
                mux_q   <= MUX_PARITY;
              end else begin
                state_q <= S_STOP;
                mux_q   <= MUX_STOP;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
            mux_q   <= MUX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (Data_Valid) begin
              state_q  <= S_START;
              par_en_q <= PAR_EN;
              mux_q    <= MUX_START;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          idx_q    <= '0;
          mux_q    <= MUX_STOP;
          busy_q   <= 1'b0;
          ser_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are suppressed while reset is asserted so reset dominates
  always_comb begin
    ser_load  = accept;
    ser_shift = RST && (state_q == S_DATA) && cnt_last && !idx_last;
    ser_en    = ser_en_q;
    mux_sel   = mux_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - frame-queue model checker for uart_tx_ctrl at CPB=16 and CPB=1
module tb_uart_tx_ctrl;

  typedef logic [4:0] ent_t;        // {shift, ser_en, busy, mux[1:0]}
  typedef ent_t entq_t[$];

  localparam ent_t IDLE_ENT = 5'b00001;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic DV  = 1'b0;
  logic PE  = 1'b0;

  logic       ld16, sh16, en16, bz16;
  logic [1:0] mx16;
  logic       ld1, sh1, en1, bz1;
  logic [1:0] mx1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  ent_t mq[2][$];

  int loads16, shifts16, busy16, par16;
  int shifts1, busy1;
  logic [1:0] seq1[$];

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut16 (
    .CLK(CLK), .RST(RST), .Data_Valid(DV), .PAR_EN(PE),
    .ser_load(ld16), .ser_shift(sh16), .ser_en(en16), .mux_sel(mx16), .busy(bz16)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .Data_Valid(DV), .PAR_EN(PE),
    .ser_load(ld1), .ser_shift(sh1), .ser_en(en1), .mux_sel(mx1), .busy(bz1)
  );

  always #5 CLK = ~CLK;

  // Expected per-cycle outputs of one whole frame: start, 8 data bits, optional parity, stop
  function automatic entq_t build_frame(int cpb, bit p);
    entq_t f;
    int nbits;
    nbits = 2 + 8 + (p ? 1 : 0);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b == 0)
          f.push_back(5'b00100);
        else if (b <= 8)
          f.push_back({((c == cpb - 1) && (b != 8)), 1'b1, 1'b1, 2'b10});
        else if (p && b == 9)
          f.push_back(5'b00111);
        else
          f.push_back(5'b00101);
      end
    end
    return f;
  endfunction

  task automatic model_step(input int k, input int cpb, input logic ld, input logic sh,
                            input logic en, input logic bz, input logic [1:0] mx);
    ent_t  head;
    logic  exp_ld;
    logic  exp_sh;
    entq_t fr;
    head   = (mq[k].size() > 0) ? mq[k][0] : IDLE_ENT;
    exp_ld = RST && DV && (mq[k].size() <= 1);
    exp_sh = RST && head[4];
    checks++;
    if ({ld, sh, en, bz, mx} !== {exp_ld, exp_sh, head[3:0]}) begin
      errors++;
      $display("FAIL cpb%0d_cycle%0d {load,shift,en,busy,mux} got %b required %b",
               cpb, cyc, {ld, sh, en, bz, mx}, {exp_ld, exp_sh, head[3:0]});
    end
    if (mq[k].size() > 0) void'(mq[k].pop_front());
    if (!RST) begin
      mq[k].delete();
    end else if (exp_ld) begin
      fr = build_frame(cpb, PE);
      foreach (fr[i]) mq[k].push_back(fr[i]);
    end
  endtask

  // Single compare process: both instances checked every cycle, plus literal-pin counters
  always @(negedge CLK) begin
    cyc++;
    if (chk_on) begin
      model_step(0, 16, ld16, sh16, en16, bz16, mx16);
      model_step(1, 1, ld1, sh1, en1, bz1, mx1);
      loads16  += int'(ld16);
      shifts16 += int'(sh16);
      busy16   += int'(bz16);
      par16    += int'(mx16 == 2'b11);
      shifts1  += int'(sh1);
      busy1    += int'(bz1);
      if (bz1) seq1.push_back(mx1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic clr();
    loads16 = 0; shifts16 = 0; busy16 = 0; par16 = 0;
    shifts1 = 0; busy1 = 0;
    seq1.delete();
  endtask

  task automatic pulse(input logic par);
    PE = par;
    DV = 1'b1;
    tick();
    DV = 1'b0;
  endtask

  initial begin
    clr();
    // Test 1: reset, then reset with Data_Valid held
    RST = 1'b0;
    repeat (2) tick();
    chk_on = 1'b1;
    RST = 1'b1;
    @(negedge CLK); #1;
    chk("reset_mux", int'(mx16), 1);
    chk("reset_busy", int'(bz16), 0);
    chk("reset_strobes", int'({ld16, sh16, en16}), 0);
    tick();
    RST = 1'b0; DV = 1'b1;
    repeat (2) tick();
    @(negedge CLK); #1;
    chk("reset_dv_ld", int'(ld16), 0);
    RST = 1'b1; DV = 1'b0;
    tick();
    chk("reset_dv_mux", int'(mx16), 1);
    chk("reset_dv_busy", int'(bz16), 0);

    // Test 2: plain frame, no parity
    clr();
    pulse(1'b0);
    repeat (170) tick();
    chk("t2_loads", loads16, 1);
    chk("t2_shifts", shifts16, 7);
    chk("t2_busy", busy16, 160);
    chk("t2_parity", par16, 0);

    // Test 3: parity latched at accept survives PAR_EN dropping mid-DATA
    clr();
    pulse(1'b1);
    repeat (36) tick();
    PE = 1'b0;
    repeat (154) tick();
    chk("t3_busy", busy16, 176);
    chk("t3_parity", par16, 16);

    // Test 4: back-to-back via last STOP cycle, mid-DATA pulse ignored
    clr();
    pulse(1'b0);
    for (int i = 1; i < 160; i++) begin
      DV = (i == 50);
      tick();
    end
    DV = 1'b1;
    tick();
    DV = 1'b0;
    chk("t4_mux_after_b2b", int'(mx16), 0);
    repeat (170) tick();
    chk("t4_loads", loads16, 2);
    chk("t4_busy_continuous", busy16, 320);

    // Test 5: reset during data bit 3, then a full clean frame
    pulse(1'b0);
    repeat (69) tick();
    chk("t5_in_data", int'(mx16), 2);
    RST = 1'b0;
    tick();
    chk("t5_mux_after_rst", int'(mx16), 1);
    chk("t5_busy_after_rst", int'(bz16), 0);
    RST = 1'b1;
    tick();
    clr();
    pulse(1'b0);
    repeat (170) tick();
    chk("t5_busy", busy16, 160);
    chk("t5_shifts", shifts16, 7);

    // Test 6: CLKS_PER_BIT=1 with parity
    clr();
    pulse(1'b1);
    repeat (200) tick();
    chk("t6_len", seq1.size(), 11);
    chk("t6_busy", busy1, 11);
    chk("t6_shifts", shifts1, 7);
    if (seq1.size() == 11) begin
      chk("t6_start", int'(seq1[0]), 0);
      for (int i = 1; i <= 8; i++) chk("t6_data", int'(seq1[i]), 2);
      chk("t6_parity", int'(seq1[9]), 3);
      chk("t6_stop", int'(seq1[10]), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
